serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 5 +
 rtl/serial_addsub_full_adder.sv | 11 +
 rtl/serial_addsub.sv | 69 ++++++
 tb/tb_serial_addsub.sv | 139 +++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encodings and default width for the bit-serial adder/subtractor
package serial_addsub_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_addsub_full_adder.sv
// full_adder: one-bit combinational full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement add/sub, one bit per clock through a single full adder
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] areg_q, areg_d, breg_q, breg_d, acc_q, acc_d, result_q, result_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic s, co, accept, step, last;
  full_adder u_fa (.a(areg_q[0]), .b(breg_q[0]), .cin(carry_q), .sum(s), .cout(co));
  assign accept = start && state_q != RUN;
  assign step   = state_q == RUN;
  assign last   = step && cnt_q == CW'(WIDTH - 1);
  // bits accumulate internally so the visible result only moves on accept and completion
  always_comb begin
    state_d  = accept ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
    areg_d   = accept ? a : step ? areg_q >> 1 : areg_q;
    breg_d   = accept ? (sub ? ~b : b) : step ? breg_q >> 1 : breg_q;
    carry_d  = accept ? sub : step ? co : carry_q;
    cnt_d    = accept ? '0 : step ? cnt_q + 1'b1 : cnt_q;
    acc_d    = accept ? '0 : step ? {s, acc_q[WIDTH-1:1]} : acc_q;
    result_d = accept ? '0 : last ? {s, acc_q[WIDTH-1:1]} : result_q;
    cout_d   = last ? co : cout_q;
    ovf_d    = last ? carry_q ^ co : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      areg_q   <= '0;
      breg_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vector table plus multi-cycle corner sequences for serial_addsub
module tb_serial_addsub;
  logic clk = 1'b0, rst, start, sub, busy, done, cout, ovf;
  logic [7:0] a, b, result;
  int tests = 0, failed = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic       c;
    logic       v;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0; sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
  endtask

  // returns cycles from the start cycle to done, and busy cycles seen; optional ignored start pulse
  task automatic wait_done(input int glitch_at, output int cyc, output int bz);
    cyc = 1; bz = 0;
    while (1) begin
      start = (cyc == glitch_at);
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) break;
      if (busy) bz++;
      if (cyc > 30) begin
        chk("done_timeout", cyc, 9);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    vec_t vt[8];
    int cyc, bz;
    logic seen;
    vt[0] = '{1'b0, 8'h25, 8'h17, 8'h3C, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[6] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};
    vt[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vt[i].s, vt[i].x, vt[i].y);
      wait_done(0, cyc, bz);
      chk($sformatf("v%0d_latency", i), cyc, 9);
      chk($sformatf("v%0d_busy_cycles", i), bz, 8);
      chk($sformatf("v%0d_result", i), result, vt[i].r);
      chk($sformatf("v%0d_cout", i), cout, vt[i].c);
      chk($sformatf("v%0d_ovf", i), ovf, vt[i].v);
    end
    @(negedge clk);
    chk("hold_done_low", done, 0);
    chk("hold_result", result, 8'h00);
    chk("hold_ovf", ovf, 1);

    // reset 4 cycles into RUN aborts without a done pulse
    start_op(1'b0, 8'h7F, 8'h7F);
    repeat (3) @(negedge clk);
    chk("mid_run_result_clear", result, 0);
    chk("mid_run_ovf_held", ovf, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= done;
    end
    chk("abort_no_done", seen, 0);
    start_op(1'b0, 8'h01, 8'h01);
    wait_done(0, cyc, bz);
    chk("after_abort_result", result, 8'h02);

    // start pulse 3 cycles into RUN is ignored
    start_op(1'b0, 8'h25, 8'h17);
    wait_done(3, cyc, bz);
    chk("ignore_latency", cyc, 9);
    chk("ignore_result", result, 8'h3C);
    chk("ignore_cout", cout, 0);
    @(negedge clk);
    chk("ignore_no_restart", busy, 0);

    // back-to-back: start held in the done cycle
    start_op(1'b0, 8'h01, 8'h02);
    wait_done(0, cyc, bz);
    chk("b2b_first_result", result, 8'h03);
    start = 1'b1; sub = 1'b0; a = 8'h55; b = 8'hAA;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    chk("b2b_busy", busy, 1);
    chk("b2b_result_cleared", result, 0);
    wait_done(0, cyc, bz);
    chk("b2b_latency", cyc, 9);
    chk("b2b_result", result, 8'hFF);
    chk("b2b_cout", cout, 0);
    chk("b2b_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
